// File: rtl/aes_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_cipher_iter
//
// Purpose:
//   Iterative AES forward cipher. It computes one round per clock and works on
//   one 128-bit block at a time. The key schedule is expanded outside this
//   block and arrives on port w.
//
// Parameters:
//   nk  key length in 32-bit words (4/6/8)
//   nr  number of rounds (10/12/14); must equal nk + 6
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   plaintext block offered
//   in_ready   block can be accepted (high only while idle)
//   in_block   plaintext; [127:120] is state byte 0, column-major
//   w          expanded key; round key r sits at w[128*(nr-r) +: 128]
//   out_valid  ciphertext available (high only in DONE)
//   out_ready  consumer accepts the ciphertext
//   out_block  ciphertext, same byte order as in_block
//   busy       high while a block is in flight or waiting to be taken
//
// Configuration macro:
//   AES_KEY_LATCH_EN  when defined, w is captured on the acceptance edge and
//                     the rounds use that copy, so w may change while busy.
//                     When undefined, the round keys come straight from w.
//                     In that case w must stay stable until out_valid.
// ---------------------------------------------------------------------------
module aes_cipher_iter #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_block,
    input  logic [128*(nr+1)-1:0] w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_block,
    output logic                  busy
);

    localparam int key_width = 128 * (nr + 1);
    localparam logic [3:0] last_round = 4'(nr);

    // Standard AES forward S-box, byte 0x00 at the most significant end.
    localparam logic [2047:0] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // AES ties the round count to the key length, so reject a mismatched pair
    // when the design is elaborated.
    if (nr != nk + 6) begin : g_bad_key_config
        $error("aes_cipher_iter: nr must equal nk + 6");
    end

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    fsm_e fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_block_q, out_block_d;
    logic [3:0]   counter_q, counter_d;

    logic [key_width-1:0] round_keys;
    logic [127:0]         rk0;
    logic [127:0]         round_key;
    logic [127:0]         after_sub_shift;
    logic [127:0]         after_mix;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return sbox_table[8*(255 - int'(x)) +: 8];
    endfunction

    // Multiply by x in GF(2^8) with the reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows in one pass. Byte index is row + 4*column, and
    // row r rotates left by r positions.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r_out;
        r_out = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r_out[127 - 8*(4*col + row) -: 8] =
                    sbox(s[127 - 8*(4*((col + row) % 4) + row) -: 8]);
            end
        end
        return r_out;
    endfunction

    // MixColumns in shared-xor form: b_i = a_i ^ t ^ 2*(a_i ^ a_{i+1}), where
    // t is the xor of the whole column.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3, t;
        m = '0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127 - 32*col -: 8];
            a1 = s[119 - 32*col -: 8];
            a2 = s[111 - 32*col -: 8];
            a3 = s[103 - 32*col -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            m[127 - 32*col -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            m[119 - 32*col -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            m[111 - 32*col -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            m[103 - 32*col -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return m;
    endfunction

`ifdef AES_KEY_LATCH_EN
    logic [key_width-1:0] key_q, key_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign round_keys = key_q;
`else
    assign round_keys = w;
`endif

    // Round 0 is always taken from the live port. The latched copy, when it
    // exists, is only written on that same edge.
    assign rk0 = w[128*nr +: 128];

    // The counter never exceeds nr, so this slice stays in range.
    assign round_key       = round_keys[128*(nr - int'(counter_q)) +: 128];
    assign after_sub_shift = sub_shift(state_q);
    assign after_mix       = mix_columns(after_sub_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            out_block_q <= '0;
            counter_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            out_block_q <= out_block_d;
            counter_q   <= counter_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate rounds, then hold the result
    // until the consumer takes it.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        out_block_d = out_block_q;
        counter_d   = counter_q;
`ifdef AES_KEY_LATCH_EN
        key_d       = key_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = in_block ^ rk0;
                    counter_d = 4'd1;
                    fsm_d     = ROUND;
`ifdef AES_KEY_LATCH_EN
                    key_d     = w;
`endif
                end
            end
            ROUND: begin
                if (counter_q == last_round) begin
                    // The final round has no MixColumns.
                    state_d     = after_sub_shift ^ round_key;
                    out_block_d = after_sub_shift ^ round_key;
                    counter_d   = '0;
                    fsm_d       = DONE;
                end else begin
                    state_d   = after_mix ^ round_key;
                    counter_d = counter_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_block = out_block_q;

endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 The block SHALL have parameter nk, default 4, key length in 32-bit words (4/6/8).
REQ-002 The block SHALL have parameter nr, default 10, round count (10/12/14).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, plaintext block offered.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept plaintext.
REQ-007 The block SHALL have port in_block, input, 128, plaintext; [127:120] = state byte 0, column-major (FIPS-197).
REQ-008 The block SHALL have port w, input, 128*(nr+1), expanded key; round key r = w[128*(nr-r) +: 128], so round 0 is at the MSBs.
REQ-009 The block SHALL have port out_valid, output, 1, ciphertext available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts ciphertext.
REQ-011 The block SHALL have port out_block, output, 128, ciphertext, same byte order as in_block.
REQ-012 The block SHALL have port busy, output, 1, high in ROUND or DONE.

Function
REQ-013 The block SHALL implement FSM states IDLE, ROUND and DONE.
REQ-014 in_ready SHALL be high only in IDLE.
REQ-015 Acceptance SHALL occur on a clock edge with in_valid && in_ready; on that edge, state <= in_block ^ rk0, round counter <= 1, FSM -> ROUND.
REQ-016 Each ROUND cycle SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[counter]), then increment the counter.
REQ-017 In the round where counter == nr, MixColumns SHALL be skipped; the result SHALL be registered into out_block and the FSM SHALL go to DONE.
REQ-018 Latency from the acceptance edge to the first cycle with out_valid high SHALL be exactly nr edges (10/12/14); the counter SHALL be 4 bits wide and SHALL never exceed nr.
REQ-019 out_valid SHALL be high only in DONE; out_block SHALL hold stable while out_valid && !out_ready.
REQ-020 On an edge with out_valid && out_ready, the FSM SHALL go to IDLE, out_valid SHALL go low next cycle, and in_ready SHALL go high next cycle.
REQ-021 The block SHALL process one block at a time, with no overlap; in_valid SHALL be ignored in ROUND and DONE.
REQ-022 in_block SHALL be sampled only on the acceptance edge; later changes SHALL have no effect.
REQ-023 The S-box SHALL be the standard AES forward S-box, and MixColumns SHALL use GF(2^8) with polynomial 0x11b.

Reset
REQ-024 Asserting rst SHALL force IDLE immediately; in_ready=1, out_valid=0, busy=0, out_block=0, counter=0, state register=0.
REQ-025 Reset asserted mid-operation SHALL abort the block, and no out_valid pulse SHALL follow for it.
REQ-026 After rst deasserts, the first acceptance SHALL be possible on the first clock edge.

Configuration
REQ-027 The feature SHALL be controlled by macro AES_KEY_LATCH_EN.
REQ-028 With AES_KEY_LATCH_EN defined, w SHALL be copied into an internal register on the acceptance edge, and all rounds SHALL use the copy; w may change freely while busy.
REQ-029 Without AES_KEY_LATCH_EN, round keys SHALL be taken directly from w, w SHALL be held stable from acceptance until out_valid, and there SHALL be no key register.

Verification
REQ-030 nk=4, nr=10, w from key 000102030405060708090a0b0c0d0e0f, in_block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after acceptance.
REQ-031 nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, in_block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-032 nk=8, nr=14, key 000102...1e1f, in_block 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid -> out_block constant and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 Pulse rst at round 5 -> out_valid stays 0 and in_ready=1 immediately; a new block then completes with the correct result.
REQ-035 With AES_KEY_LATCH_EN, change w to all-zero one cycle after acceptance -> result still matches REQ-030; without the macro this case is excluded.
